// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared memory request types and arbiter enums
package mem_bus_arbiter_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] mtrans_t;

  typedef struct packed {
    addr_t       a;
    logic        we;
    logic [3:0]  be;
    mtrans_t     d;
  } mem_req_t;

  typedef enum logic {
    ARB_FETCH = 1'b0,
    ARB_DATA  = 1'b1
  } arb_owner_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - one-outstanding arbiter sharing the memory port between fetch and load/store
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4,
  parameter int STREAK_W        = $clog2(MAX_DATA_STREAK + 1)
) (
  input  logic     i_clk,
  input  logic     i_rst,

  input  logic     i_if_req_valid,
  output logic     o_if_req_ready,
  input  mem_req_t i_if_req_data,
  output logic     o_if_resp_valid,
  input  logic     i_if_resp_ready,
  output mtrans_t  o_if_resp_data,

  input  logic     i_dm_req_valid,
  output logic     o_dm_req_ready,
  input  mem_req_t i_dm_req_data,
  output logic     o_dm_resp_valid,
  input  logic     i_dm_resp_ready,
  output mtrans_t  o_dm_resp_data,

  output logic     o_mem_req_valid,
  input  logic     i_mem_req_ready,
  output mem_req_t o_mem_req_data,
  input  logic     i_mem_resp_valid,
  output logic     o_mem_resp_ready,
  input  mtrans_t  i_mem_resp_data,

  output logic     o_busy,
  output logic     o_owner
);

  arb_state_e          r_state;
  arb_state_e          w_next_state;
  arb_owner_e          r_owner;
  logic [STREAK_W-1:0] r_streak;
  logic [STREAK_W-1:0] w_streak_inc;
  logic                w_grant_any;
  logic                w_grant_data;

  // Data wins a contested slot until it has used up its streak budget.
  always_comb begin
    w_grant_any  = i_if_req_valid | i_dm_req_valid;
    w_grant_data = 1'b0;
    if (i_dm_req_valid && i_if_req_valid)
      w_grant_data = (r_streak < STREAK_W'(MAX_DATA_STREAK));
    else
      w_grant_data = i_dm_req_valid;
    w_streak_inc = (r_streak == STREAK_W'(MAX_DATA_STREAK)) ? r_streak : r_streak + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state  <= ARB_IDLE;
      r_owner  <= ARB_FETCH;
      r_streak <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ARB_IDLE && w_grant_any) begin
        r_owner  <= w_grant_data ? ARB_DATA : ARB_FETCH;
        r_streak <= (w_grant_data && i_if_req_valid) ? w_streak_inc : '0;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE:  if (w_grant_any) w_next_state = ARB_ISSUE;
      ARB_ISSUE: if (i_mem_req_ready) w_next_state = ARB_WAIT;
      ARB_WAIT:  if (i_mem_resp_valid && o_mem_resp_ready) w_next_state = ARB_IDLE;
      default:   w_next_state = ARB_IDLE;
    endcase
  end

  // Responses outside WAIT are never accepted: mem_resp_ready stays low there.
  always_comb begin
    o_mem_req_valid  = 1'b0;
    o_if_req_ready   = 1'b0;
    o_dm_req_ready   = 1'b0;
    o_if_resp_valid  = 1'b0;
    o_dm_resp_valid  = 1'b0;
    o_mem_resp_ready = 1'b0;
    o_mem_req_data   = (r_owner == ARB_DATA) ? i_dm_req_data : i_if_req_data;
    o_if_resp_data   = i_mem_resp_data;
    o_dm_resp_data   = i_mem_resp_data;
    o_busy           = (r_state != ARB_IDLE);
    o_owner          = r_owner;
    case (r_state)
      ARB_ISSUE: begin
        o_mem_req_valid = 1'b1;
        if (r_owner == ARB_DATA) o_dm_req_ready = i_mem_req_ready;
        else                     o_if_req_ready = i_mem_req_ready;
      end
      ARB_WAIT: begin
        if (r_owner == ARB_DATA) begin
          o_dm_resp_valid  = i_mem_resp_valid;
          o_mem_resp_ready = i_dm_resp_ready;
        end else begin
          o_if_resp_valid  = i_mem_resp_valid;
          o_mem_resp_ready = i_if_resp_ready;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int          MAX_STREAK = 4;
  localparam logic [31:0] MAGIC      = 32'h5A5A_A5A5;

  logic     clk, rst;
  logic     if_req_valid, if_req_ready, if_resp_valid, if_resp_ready;
  logic     dm_req_valid, dm_req_ready, dm_resp_valid, dm_resp_ready;
  logic     mem_req_valid, mem_req_ready, mem_resp_valid, mem_resp_ready;
  mem_req_t if_req_data, dm_req_data, mem_req_data;
  mtrans_t  if_resp_data, dm_resp_data, mem_resp_data;
  logic     busy, owner;
  int       checks, errors;

  mem_bus_arbiter #(.MAX_DATA_STREAK(MAX_STREAK)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req_valid(if_req_valid), .o_if_req_ready(if_req_ready), .i_if_req_data(if_req_data),
    .o_if_resp_valid(if_resp_valid), .i_if_resp_ready(if_resp_ready), .o_if_resp_data(if_resp_data),
    .i_dm_req_valid(dm_req_valid), .o_dm_req_ready(dm_req_ready), .i_dm_req_data(dm_req_data),
    .o_dm_resp_valid(dm_resp_valid), .i_dm_resp_ready(dm_resp_ready), .o_dm_resp_data(dm_resp_data),
    .o_mem_req_valid(mem_req_valid), .i_mem_req_ready(mem_req_ready), .o_mem_req_data(mem_req_data),
    .i_mem_resp_valid(mem_resp_valid), .o_mem_resp_ready(mem_resp_ready), .i_mem_resp_data(mem_resp_data),
    .o_busy(busy), .o_owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req_valid = 0; dm_req_valid = 0; if_req_data = '0; dm_req_data = '0;
    if_resp_ready = 0; dm_resp_ready = 0; mem_req_ready = 0;
    mem_resp_valid = 0; mem_resp_data = '0;
  endtask

  function automatic mem_req_t mk(input addr_t a, input logic we, input logic [3:0] be, input mtrans_t d);
    mem_req_t t;
    t.a = a; t.we = we; t.be = be; t.d = d;
    return t;
  endfunction

  // Drives one full transaction with a 1-cycle memory; reports what was observed.
  task automatic run_txn(output logic own, output mem_req_t pay, output logic [1:0] rv,
                         output mtrans_t rd, output logic ok);
    ok = 0; own = 0; pay = '0; rv = '0; rd = '0;
    mem_req_ready = 1; if_resp_ready = 1; dm_resp_ready = 1; mem_resp_valid = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (mem_req_valid) begin own = owner; pay = mem_req_data; ok = 1; break; end
      cyc();
    end
    if (!ok) return;
    cyc();
    mem_resp_valid = 1; mem_resp_data = pay.a ^ MAGIC;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (mem_resp_ready) begin
        rv = {dm_resp_valid, if_resp_valid};
        rd = own ? dm_resp_data : if_resp_data;
        ok = 1;
        cyc();
        mem_resp_valid = 0;
        break;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    if_req_valid = 1; dm_req_valid = 1; mem_req_ready = 1; if_resp_ready = 1; dm_resp_ready = 1;
    #1;
    checks++;
    if ({busy, owner, mem_req_valid, if_req_ready, dm_req_ready} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, owner, mem_req_valid, if_req_ready, dm_req_ready});
    end
    checks++;
    if ({if_resp_valid, dm_resp_valid, mem_resp_ready} !== 3'b0) begin
      errors++; $display("FAIL reset_resp: got %b expected 000", {if_resp_valid, dm_resp_valid, mem_resp_ready});
    end
    clear_inputs();
    rst = 1;
    cyc();
  endtask

  task automatic test_single_fetch();
    mem_req_t p;
    p = mk(32'h1000, 1'b0, 4'hF, '0);
    if_req_data = p; if_req_valid = 1; mem_req_ready = 1; if_resp_ready = 1; dm_resp_ready = 1;
    #1;
    checks++;
    if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL sf_c0_idle: got %b expected 0", mem_req_valid); end
    cyc(); #1;
    checks++;
    if (mem_req_valid !== 1'b1 || if_req_ready !== 1'b1 || mem_req_data !== p) begin
      errors++; $display("FAIL sf_c1_issue: got v=%b r=%b a=%h expected v=1 r=1 a=%h", mem_req_valid, if_req_ready, mem_req_data.a, p.a);
    end
    cyc();
    if_req_valid = 0; mem_resp_valid = 1; mem_resp_data = 32'hCAFE_0001;
    #1;
    checks++;
    if (if_resp_valid !== 1'b1 || if_resp_data !== 32'hCAFE_0001) begin
      errors++; $display("FAIL sf_c2_resp: got v=%b d=%h expected v=1 d=cafe0001", if_resp_valid, if_resp_data);
    end
    checks++;
    if (dm_resp_valid !== 1'b0 || mem_resp_ready !== 1'b1) begin
      errors++; $display("FAIL sf_c2_route: got dmv=%b mrr=%b expected dmv=0 mrr=1", dm_resp_valid, mem_resp_ready);
    end
    cyc();
    mem_resp_valid = 0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL sf_c3_busy: got %b expected 0", busy); end
    clear_inputs();
    cyc();
  endtask

  task automatic test_simultaneous();
    mem_req_t fp, dp, pay;
    logic own, ok;
    logic [1:0] rv;
    mtrans_t rd;
    fp = mk(32'h2000, 1'b0, 4'hF, '0);
    dp = mk(32'h3000, 1'b0, 4'hF, '0);
    if_req_data = fp; dm_req_data = dp; if_req_valid = 1; dm_req_valid = 1;
    run_txn(own, pay, rv, rd, ok);
    dm_req_valid = 0;
    checks++;
    if (!ok || own !== 1'b1 || pay !== dp) begin
      errors++; $display("FAIL sim_first: got ok=%b own=%b a=%h expected ok=1 own=1 a=%h", ok, own, pay.a, dp.a);
    end
    checks++;
    if (rv !== 2'b10 || rd !== (dp.a ^ MAGIC)) begin
      errors++; $display("FAIL sim_first_route: got rv=%b d=%h expected rv=10 d=%h", rv, rd, dp.a ^ MAGIC);
    end
    run_txn(own, pay, rv, rd, ok);
    checks++;
    if (!ok || own !== 1'b0 || pay !== fp) begin
      errors++; $display("FAIL sim_second: got ok=%b own=%b a=%h expected ok=1 own=0 a=%h", ok, own, pay.a, fp.a);
    end
    checks++;
    if (rv !== 2'b01 || rd !== (fp.a ^ MAGIC)) begin
      errors++; $display("FAIL sim_second_route: got rv=%b d=%h expected rv=01 d=%h", rv, rd, fp.a ^ MAGIC);
    end
    clear_inputs();
    cyc();
  endtask

  task automatic test_starvation();
    mem_req_t pay;
    logic own, ok, exp_own;
    logic [1:0] rv;
    mtrans_t rd;
    if_req_data = mk(32'h4000, 1'b0, 4'hF, '0); dm_req_data = mk(32'h5000, 1'b0, 4'hF, '0);
    if_req_valid = 1; dm_req_valid = 1;
    for (int i = 0; i < MAX_STREAK + 2; i++) begin
      run_txn(own, pay, rv, rd, ok);
      exp_own = (i == MAX_STREAK) ? 1'b0 : 1'b1;
      checks++;
      if (!ok || own !== exp_own) begin
        errors++; $display("FAIL starve_grant%0d: got ok=%b own=%b expected ok=1 own=%b", i, ok, own, exp_own);
      end
    end
    clear_inputs();
    cyc();
  endtask

  task automatic test_backpressure();
    mem_req_t p;
    p = mk(32'h6000, 1'b0, 4'hF, '0);
    if_req_data = p; if_req_valid = 1; mem_req_ready = 0; if_resp_ready = 1;
    cyc();
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_data !== p || if_req_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b a=%h r=%b expected v=1 a=%h r=0", k, mem_req_valid, mem_req_data.a, if_req_ready, p.a);
      end
      cyc();
    end
    mem_req_ready = 1;
    #1;
    checks++;
    if (if_req_ready !== 1'b1) begin errors++; $display("FAIL bp_accept: got %b expected 1", if_req_ready); end
    cyc();
    if_req_valid = 0;
    #1;
    checks++;
    if (mem_req_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL bp_single: got v=%b busy=%b expected v=0 busy=1", mem_req_valid, busy);
    end
    mem_resp_valid = 1; mem_resp_data = 32'h1;
    cyc();
    mem_resp_valid = 0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL bp_done: got %b expected 0", busy); end
    clear_inputs();
    cyc();
  endtask

  task automatic test_resp_stall();
    mem_req_t p;
    p = mk(32'h7000, 1'b1, 4'b1100, 32'h1234_5678);
    dm_req_data = p; dm_req_valid = 1; mem_req_ready = 1; dm_resp_ready = 0;
    cyc(); #1;
    checks++;
    if (mem_req_data !== p || dm_req_ready !== 1'b1) begin
      errors++; $display("FAIL rs_issue: got we=%b be=%b r=%b expected we=1 be=1100 r=1", mem_req_data.we, mem_req_data.be, dm_req_ready);
    end
    cyc();
    dm_req_valid = 0; mem_resp_valid = 1; mem_resp_data = 32'h0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (mem_resp_ready !== 1'b0 || busy !== 1'b1 || dm_resp_valid !== 1'b1) begin
        errors++; $display("FAIL rs_stall%0d: got mrr=%b busy=%b dv=%b expected mrr=0 busy=1 dv=1", k, mem_resp_ready, busy, dm_resp_valid);
      end
      cyc();
    end
    dm_resp_ready = 1;
    #1;
    checks++;
    if (mem_resp_ready !== 1'b1) begin errors++; $display("FAIL rs_release: got %b expected 1", mem_resp_ready); end
    cyc();
    mem_resp_valid = 0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rs_done: got %b expected 0", busy); end
    clear_inputs();
    cyc();
  endtask

  task automatic test_async_reset();
    mem_req_t pay, fp;
    logic own, ok;
    logic [1:0] rv;
    mtrans_t rd;
    dm_req_data = mk(32'h8000, 1'b0, 4'hF, '0); dm_req_valid = 1;
    mem_req_ready = 1; dm_resp_ready = 1; if_resp_ready = 1;
    cyc(); cyc();
    dm_req_valid = 0;
    #1;
    checks++;
    if (busy !== 1'b1 || owner !== 1'b1 || mem_resp_ready !== 1'b1) begin
      errors++; $display("FAIL ar_pre: got busy=%b own=%b mrr=%b expected 1 1 1", busy, owner, mem_resp_ready);
    end
    #2;
    rst = 0;
    #1;
    checks++;
    if ({busy, owner, mem_req_valid, if_req_ready, dm_req_ready, if_resp_valid, dm_resp_valid, mem_resp_ready} !== 8'b0) begin
      errors++; $display("FAIL ar_clear: got %b expected 00000000",
        {busy, owner, mem_req_valid, if_req_ready, dm_req_ready, if_resp_valid, dm_resp_valid, mem_resp_ready});
    end
    cyc();
    rst = 1;
    fp = mk(32'h9000, 1'b0, 4'hF, '0);
    if_req_data = fp; if_req_valid = 1;
    run_txn(own, pay, rv, rd, ok);
    checks++;
    if (!ok || own !== 1'b0 || pay !== fp || rv !== 2'b01) begin
      errors++; $display("FAIL ar_after: got ok=%b own=%b a=%h rv=%b expected ok=1 own=0 a=%h rv=01", ok, own, pay.a, rv, fp.a);
    end
    clear_inputs();
    cyc();
  endtask

  // Transaction-level model: queues of pending requests, grant rule applied at each accept.
  task automatic test_random();
    mem_req_t ifq[$], dmq[$];
    mem_req_t exp_pay;
    int n_if, n_dm, total, done, streak, delay, cycles;
    logic pend, cur_own, exp_data, acc, rsp;
    addr_t cur_a;
    rst = 0; #1; rst = 1;
    cyc();
    n_if = $urandom_range(10, 25); n_dm = $urandom_range(10, 25);
    for (int i = 0; i < n_if; i++) ifq.push_back(mk($urandom & 32'hFFFF_FFFC, 1'b0, 4'hF, '0));
    for (int i = 0; i < n_dm; i++)
      dmq.push_back(mk($urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom));
    total = n_if + n_dm; done = 0; streak = 0; delay = 0; cycles = 0;
    pend = 0; cur_own = 0; cur_a = '0; exp_data = 0; exp_pay = '0;
    while (done < total && cycles < 4000) begin
      cycles++;
      if_req_valid = (ifq.size() > 0); if (ifq.size() > 0) if_req_data = ifq[0];
      dm_req_valid = (dmq.size() > 0); if (dmq.size() > 0) dm_req_data = dmq[0];
      mem_req_ready  = ($urandom_range(0, 3) != 0);
      mem_resp_valid = pend && (delay == 0);
      mem_resp_data  = cur_a ^ MAGIC;
      if_resp_ready  = ($urandom_range(0, 2) != 0);
      dm_resp_ready  = ($urandom_range(0, 2) != 0);
      #1;
      acc = mem_req_valid && mem_req_ready;
      rsp = mem_resp_valid && mem_resp_ready;
      if (mem_resp_valid) begin
        checks++;
        if (busy !== 1'b1 || mem_req_valid !== 1'b0) begin
          errors++; $display("FAIL rnd_resp_in_wait: got busy=%b mrv=%b expected busy=1 mrv=0", busy, mem_req_valid);
        end
        checks++;
        if ({dm_resp_valid, if_resp_valid} !== (cur_own ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL rnd_route: got %b expected %b", {dm_resp_valid, if_resp_valid}, cur_own ? 2'b10 : 2'b01);
        end
        checks++;
        if (mem_resp_ready !== (cur_own ? dm_resp_ready : if_resp_ready)) begin
          errors++; $display("FAIL rnd_resp_ready: got %b expected %b", mem_resp_ready, cur_own ? dm_resp_ready : if_resp_ready);
        end
        checks++;
        if ((cur_own ? dm_resp_data : if_resp_data) !== (cur_a ^ MAGIC)) begin
          errors++; $display("FAIL rnd_resp_data: got %h expected %h", cur_own ? dm_resp_data : if_resp_data, cur_a ^ MAGIC);
        end
      end
      if (acc) begin
        exp_data = (dmq.size() > 0) && ((ifq.size() == 0) || (streak < MAX_STREAK));
        if (exp_data && ifq.size() > 0) streak = (streak < MAX_STREAK) ? streak + 1 : MAX_STREAK;
        else streak = 0;
        exp_pay = exp_data ? dmq[0] : ifq[0];
        checks++;
        if ({dm_req_ready, if_req_ready} !== (exp_data ? 2'b10 : 2'b01) || owner !== exp_data) begin
          errors++; $display("FAIL rnd_grant: got rdy=%b own=%b expected rdy=%b own=%b",
            {dm_req_ready, if_req_ready}, owner, exp_data ? 2'b10 : 2'b01, exp_data);
        end
        checks++;
        if (mem_req_data !== exp_pay) begin
          errors++; $display("FAIL rnd_payload: got a=%h expected a=%h", mem_req_data.a, exp_pay.a);
        end
      end
      cyc();
      if (rsp) begin pend = 0; done++; end
      else if (pend && delay > 0) delay--;
      if (acc) begin
        pend = 1; delay = $urandom_range(0, 2); cur_own = exp_data; cur_a = exp_pay.a;
        if (exp_data) void'(dmq.pop_front()); else void'(ifq.pop_front());
      end
    end
    checks++;
    if (done != total) begin errors++; $display("FAIL rnd_complete: got %0d responses expected %0d", done, total); end
    clear_inputs();
    cyc();
  endtask

  initial begin
    checks = 0; errors = 0;
    clear_inputs();
    rst = 0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_backpressure();
    test_resp_stall();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single core memory port between two requesters: instruction fetch and the load/store execution unit. Holds exactly one outstanding transaction at a time and routes the response back to the requester that issued it. Data accesses take priority, with a bounded streak so fetch cannot starve. Sits between the fetch/mem units and the external memory decoupled port.

Parameters:
MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch is pending before fetch is forced to win (>=1)
STREAK_W, $clog2(MAX_DATA_STREAK+1), width of the streak counter

Ports:
clk  input  1  core clock
rst  input  1  reset, asynchronous, active-low
if_req  decoupled.in  mem request payload {a, we, be, d}  fetch requests; fetch always drives we=0
if_resp  decoupled.out  mtrans  fetch read data
dm_req  decoupled.in  mem request payload {a, we, be, d}  load/store requests
dm_resp  decoupled.out  mtrans  load/store read data (also returned for stores)
mem_req  decoupled.out  mem request payload {a, we, be, d}  to memory
mem_resp  decoupled.in  mtrans  from memory
busy  output  1  high when state != IDLE
owner  output  1  current or last grant: 0=fetch, 1=data

Behaviour:
- Reset (rst low, async): state=IDLE, owner=fetch, streak=0. All valid/ready outputs are 0 and busy=0.
- FSM states are IDLE, ISSUE and WAIT.
- IDLE:
  - No request valid: stay in IDLE.
  - Exactly one valid: grant it.
  - Both valid: grant data if streak < MAX_DATA_STREAK, otherwise grant fetch.
  - Grant is registered: owner updates and state -> ISSUE next cycle. No request is forwarded in IDLE, which gives 1 cycle of arbitration latency.
- ISSUE:
  - mem_req.valid=1; mem_req.data is muxed combinationally from the owner's request payload.
  - Owner's req.ready = mem_req.ready; the non-owner's req.ready = 0.
  - On mem_req.ready: -> WAIT.
  - A requester must hold valid and payload stable until its ready; a drop of valid in ISSUE is an assertion failure.
- WAIT:
  - mem_req.valid=0.
  - Owner's resp.valid = mem_resp.valid and owner's resp.data = mem_resp.data; mem_resp.ready = owner's resp.ready.
  - The non-owner sees resp.valid=0.
  - On mem_resp.valid && mem_resp.ready: -> IDLE.
- Minimum transaction: IDLE -> ISSUE -> WAIT -> IDLE, i.e. 3 cycles with a 1-cycle memory.
- Streak counter, updated on grant in IDLE:
  - Data granted while fetch valid: streak+1, saturating at MAX_DATA_STREAK.
  - Fetch granted: streak=0.
  - Data granted with no fetch valid: streak=0.
- Memory responses arriving in IDLE or ISSUE are illegal. Memory responds no earlier than the cycle after acceptance. The bench asserts this; the RTL drops such a response (mem_resp.ready=0 outside WAIT).
- Exceptions such as misalignment are resolved inside the requesters and never reach the arbiter, so every accepted request produces exactly one response.
- Reset mid-transaction returns the FSM to IDLE. The memory side shares the same reset, so no stale response is expected.
- busy = (state != IDLE); owner is a registered output.

Decomposition:
- Shared package (types.sv): arb_owner_e {ARB_FETCH=0, ARB_DATA=1} and arb_state_e {ARB_IDLE, ARB_ISSUE, ARB_WAIT}.
- The mem request payload struct {addr a; logic we; logic [3:0] be; mtrans d} lives in the package for reuse by fetch, mem and the arbiter.
- No sub-module; the grant pick is a single always_comb.

Test Plan:
- Single fetch: if_req a=0x1000 with 1-cycle memory -> mem_req.valid in cycle 1, if_resp.valid with memory data in cycle 2, dm_resp never valid, busy low in cycle 3.
- Simultaneous: if_req and dm_req both valid at cycle 0 with streak=0 -> data granted first (owner=1), fetch granted on the next IDLE, and each response is routed only to its requester.
- Starvation bound, MAX_DATA_STREAK=4: fetch held valid while dm_req is reissued back-to-back -> exactly 4 data grants, then a fetch grant, then streak=0.
- Backpressure: mem_req.ready held low for 5 cycles in ISSUE -> mem_req payload stable and owner req.ready=0 throughout; a single accept when ready rises.
- Response stall: dm_resp.ready low for 3 cycles in WAIT -> mem_resp.ready low, state stays WAIT; a store with we=1, be=0b1100 completes when ready rises.
- Async reset asserted in WAIT mid-cycle -> busy, all valid/ready outputs and owner go to 0 immediately; a new fetch is accepted after rst rises.
